uart_frame_ctrl: RTL and testbench
==================================

Name: uart_frame_ctrl

Overview:
- Frame-level controller behind the UART receiver in the serial-to-seven-segment path.
- Consumes the receiver's byte stream (8-bit data + 1-cycle valid strobe) and sequences it through a fixed command-frame protocol.
- Executes valid frames into the display register file (6 BCD digits, decimal points, display enable) that feeds the seg driver.
- Flags malformed or timed-out frames.

Parameters:
- HEAD_BYTE, 8'hA5, frame start byte.
- TIMEOUT_MAX, 21700, inter-byte timeout in sys_clk cycles (about 5 byte times at 115200 baud, 50 MHz).
- TMR_W, 16, timeout counter width; must hold TIMEOUT_MAX-1.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid when rx_flag=1
- rx_flag  in  1  1-cycle byte-valid strobe
- disp_data  out  24  6 digits x 4 bit; digit0 = [3:0]
- disp_point  out  6  decimal point per digit, bit i = digit i
- seg_en  out  1  display enable
- frame_ok  out  1  1-cycle pulse, frame executed
- frame_err  out  1  1-cycle pulse, frame rejected or timed out
- err_cnt  out  8  saturating error count
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: reset sys_rst_n, asynchronous, active-low; clock sys_clk. All outputs are registered.
- Reset values: disp_data=24'h0, disp_point=6'h0, seg_en=1, frame_ok=0, frame_err=0, err_cnt=0, state=IDLE, timer=0.
- Frame format (checksum feature off): HEAD_BYTE, ADDR, DATA.
- FSM states: IDLE, GET_ADDR, GET_DATA, [GET_CHK], EXEC.
- IDLE:
  - rx_flag with rx_data==HEAD_BYTE -> GET_ADDR.
  - Any other byte is silently discarded: no error, stay in IDLE.
- GET_ADDR: on rx_flag, latch addr=rx_data -> GET_DATA.
- GET_DATA: on rx_flag, latch data=rx_data -> EXEC (or GET_CHK if the feature is on).
- Bytes inside a frame are never compared to HEAD_BYTE. A 0xA5 in ADDR or DATA is payload, not a resync.
- EXEC lasts exactly 1 cycle, then -> IDLE. Commands by addr:
  - 8'h00-8'h05: digit[addr] <= data[3:0]; data[7:4] ignored.
  - 8'h06: disp_point <= data[5:0].
  - 8'h07: seg_en <= data[0].
  - 8'h08: disp_data <= 0 and disp_point <= 0; data ignored; seg_en unchanged.
  - Any other addr: no register change; error.
- Latency:
  - Final byte rx_flag in cycle N -> EXEC in cycle N+1.
  - Register update and frame_ok (or frame_err) visible in cycle N+2, pulse 1 cycle.
- Timeout:
  - Timer is cleared in IDLE and on every rx_flag.
  - Timer increments each cycle in GET_ADDR, GET_DATA and GET_CHK.
  - Timer==TIMEOUT_MAX-1 -> IDLE, frame_err pulse next cycle, latched addr/data discarded.
- Simultaneous rx_flag and timeout terminal count: the byte wins, timer is cleared, no error.
- rx_flag during EXEC: the byte is dropped. The protocol guarantees at least 4340 cycles between bytes.
- err_cnt:
  - +1 on each frame_err pulse; saturates at 8'hFF.
  - Cleared only by reset.
  - frame_ok and frame_err are mutually exclusive.
- Reset mid-frame: immediate return to reset values. A partial frame has no effect.

Optional Feature:
- Macro: UART_FRAME_CKSUM_EN.
- Defined:
  - Frame is HEAD, ADDR, DATA, CHK; GET_DATA -> GET_CHK.
  - On the CHK rx_flag, CHK == ADDR ^ DATA -> EXEC.
  - Otherwise -> IDLE with frame_err at N+2, no register change.
  - Timeout also applies in GET_CHK.
- Undefined: GET_CHK does not exist; the 3-byte frame executes directly after DATA.

Test Plan:
- Reset, then send A5 02 07 -> disp_data=24'h000700, frame_ok pulse 2 cycles after the last rx_flag, err_cnt=0.
- Send A5 06 3F, then A5 07 00 -> disp_point=6'h3F, seg_en=0, two frame_ok pulses.
- Send 11 22 A5 00 A5 -> leading 11 22 ignored; digit0 <= 5; frame_ok, no frame_err.
- Send A5 09 01 -> frame_err pulse, disp_data unchanged, err_cnt=1. Then A5 08 00 -> disp_data=0, disp_point=0, frame_ok.
- Send A5 03, then idle 21700 cycles -> frame_err, busy falls, err_cnt +1. Then A5 03 09 still executes (digit3=9).
- UART_FRAME_CKSUM_EN defined: A5 01 04 05 -> digit1=4, frame_ok. A5 01 04 06 -> frame_err, no change.
- Repeat 256 bad frames -> err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: frame-level controller behind the UART receiver.
// Collects HEAD/ADDR/DATA byte frames from the receiver's byte strobe and
// executes them into the 6-digit display register file feeding the seg driver.
// Optional feature macro: UART_FRAME_CKSUM_EN adds a CHK byte (ADDR ^ DATA)
// after DATA. The default build (macro undefined) uses 3-byte frames.
//
// Handshake: rx_data/rx_flag is a push-only strobe interface. A byte is
// transferred in every cycle where rx_flag=1; there is no ready/backpressure,
// so a byte arriving while the controller cannot accept it (EXEC) is lost.
module uart_frame_ctrl #(
    parameter logic [7:0] HEAD_BYTE   = 8'hA5,
    parameter int         TIMEOUT_MAX = 21700,
    parameter int         TMR_W       = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic [23:0] disp_data,
    output logic [5:0]  disp_point,
    output logic        seg_en,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        GET_CHK  = 3'd3,
        EXEC     = 3'd4
    } state_t;

    // Only the checksum needs the upper data bits; the commands use data[5:0].
`ifdef UART_FRAME_CKSUM_EN
    localparam int DATA_W = 8;
`else
    localparam int DATA_W = 6;
`endif

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [23:0]        disp_data_d;
    logic [5:0]         disp_point_d;
    logic               seg_en_d;
    logic               frame_ok_d;
    logic               frame_err_d;
    logic [7:0]         err_cnt_d;
    logic               busy_d;
    logic               tmr_done;
`ifdef UART_FRAME_CKSUM_EN
    // A bad checksum returns to IDLE at once but reports its error one cycle
    // later so that it lines up with the normal EXEC result timing.
    logic               err_pend_q, err_pend_d;
`endif

    assign tmr_done  = (timer_q == TMR_W'(TIMEOUT_MAX - 1));
    assign state_dbg = state_q;

    // Next-state, timer, byte latching and command execution.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        data_d       = data_q;
        disp_data_d  = disp_data;
        disp_point_d = disp_point;
        seg_en_d     = seg_en;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_FRAME_CKSUM_EN
        err_pend_d   = 1'b0;
        frame_err_d  = err_pend_q;
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // Anything other than the head byte is line noise: drop it.
                if (rx_flag && (rx_data == HEAD_BYTE)) begin
                    state_d = GET_ADDR;
                end
            end

            // Payload bytes are never compared against HEAD_BYTE.
            GET_ADDR: begin
                if (rx_flag) begin
                    addr_d  = rx_data;
                    timer_d = '0;
                    state_d = GET_DATA;
                end else if (tmr_done) begin
                    timer_d     = '0;
                    addr_d      = '0;
                    data_d      = '0;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            GET_DATA: begin
                if (rx_flag) begin
                    data_d  = rx_data[DATA_W-1:0];
                    timer_d = '0;
`ifdef UART_FRAME_CKSUM_EN
                    state_d = GET_CHK;
`else
                    state_d = EXEC;
`endif
                end else if (tmr_done) begin
                    timer_d     = '0;
                    addr_d      = '0;
                    data_d      = '0;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

`ifdef UART_FRAME_CKSUM_EN
            GET_CHK: begin
                if (rx_flag) begin
                    timer_d = '0;
                    if (rx_data == (addr_q ^ data_q)) begin
                        state_d = EXEC;
                    end else begin
                        addr_d     = '0;
                        data_d     = '0;
                        err_pend_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (tmr_done) begin
                    timer_d     = '0;
                    addr_d      = '0;
                    data_d      = '0;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`endif

            // Single-cycle execute; any byte arriving now is dropped.
            EXEC: begin
                timer_d    = '0;
                state_d    = IDLE;
                frame_ok_d = 1'b1;
                case (addr_q)
                    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
                        disp_data_d[{addr_q[2:0], 2'b00} +: 4] = data_q[3:0];
                    end
                    8'h06: disp_point_d = data_q[5:0];
                    8'h07: seg_en_d     = data_q[0];
                    8'h08: begin
                        disp_data_d  = '0;
                        disp_point_d = '0;
                    end
                    default: begin
                        frame_ok_d  = 1'b0;
                        frame_err_d = 1'b1;
                    end
                endcase
            end

            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Error counter saturates at 8'hFF and tracks every frame_err pulse.
    always_comb begin
        err_cnt_d = err_cnt;
        if (frame_err_d && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
        end
        busy_d = (state_d != IDLE);
    end

    // FSM state, inter-byte timer and latched frame fields.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef UART_FRAME_CKSUM_EN
    // Deferred checksum-error flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= err_pend_d;
        end
    end
`endif

    // Registered display file, status pulses and error count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_data  <= 24'h0;
            disp_point <= 6'h0;
            seg_en     <= 1'b1;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= 8'h0;
            busy       <= 1'b0;
        end else begin
            disp_data  <= disp_data_d;
            disp_point <= disp_point_d;
            seg_en     <= seg_en_d;
            frame_ok   <= frame_ok_d;
            frame_err  <= frame_err_d;
            err_cnt    <= err_cnt_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed self-checking bench for uart_frame_ctrl.
// Works in both the default build and with UART_FRAME_CKSUM_EN defined.
module tb_uart_frame_ctrl;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_flag   = 1'b0;
    logic [23:0] disp_data;
    logic [5:0]  disp_point;
    logic        seg_en;
    logic        frame_ok;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;
    logic [2:0]  state_dbg;

    int          checks      = 0;
    int          errors      = 0;
    logic [7:0]  exp_err_cnt = 8'h00;

    uart_frame_ctrl dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_data    (rx_data),
        .rx_flag    (rx_flag),
        .disp_data  (disp_data),
        .disp_point (disp_point),
        .seg_en     (seg_en),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // 50 MHz clock
    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Byte strobed for exactly one cycle; returns in the following cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_flag = 1'b0;
        rx_data = 8'h00;
    endtask

    // Full frame; returns in the cycle after the final byte (EXEC cycle).
    task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hA5);
        idle(2);
        send_byte(a);
        idle(2);
        send_byte(d);
`ifdef UART_FRAME_CKSUM_EN
        idle(2);
        send_byte(a ^ d);
`endif
    endtask

    // Checks result pulses at N+1, N+2, N+3 after the final byte in cycle N.
    task automatic end_frame(input string tag, input logic ok, input logic err);
        chk({tag, "_ok_n1"}, {31'd0, frame_ok}, 32'd0);
        chk({tag, "_err_n1"}, {31'd0, frame_err}, 32'd0);
        idle(1);
        chk({tag, "_ok_n2"}, {31'd0, frame_ok}, {31'd0, ok});
        chk({tag, "_err_n2"}, {31'd0, frame_err}, {31'd0, err});
        chk({tag, "_busy_n2"}, {31'd0, busy}, 32'd0);
        if (err && (exp_err_cnt != 8'hFF)) exp_err_cnt = exp_err_cnt + 8'd1;
        chk({tag, "_errcnt"}, {24'd0, err_cnt}, {24'd0, exp_err_cnt});
        idle(1);
        chk({tag, "_ok_n3"}, {31'd0, frame_ok}, 32'd0);
        chk({tag, "_err_n3"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_disp_data", {8'd0, disp_data}, 32'h0);
        chk("rst_disp_point", {26'd0, disp_point}, 32'h0);
        chk("rst_seg_en", {31'd0, seg_en}, 32'd1);
        chk("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        sys_rst_n = 1'b1;
        idle(2);

        // A5 02 07 -> digit2 = 7
        send_frame(8'h02, 8'h07);
        chk("f1_busy_exec", {31'd0, busy}, 32'd1);
        end_frame("f1", 1'b1, 1'b0);
        chk("f1_disp", {8'd0, disp_data}, 32'h000700);

        // Points and display enable
        send_frame(8'h06, 8'h3F);
        end_frame("pt", 1'b1, 1'b0);
        chk("pt_val", {26'd0, disp_point}, 32'h3F);
        send_frame(8'h07, 8'h00);
        end_frame("en", 1'b1, 1'b0);
        chk("en_val", {31'd0, seg_en}, 32'd0);

        // Leading junk ignored, A5 as DATA payload
        send_byte(8'h11);
        idle(2);
        chk("junk1_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h22);
        idle(2);
        chk("junk2_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h00, 8'hA5);
        end_frame("d0", 1'b1, 1'b0);
        chk("d0_disp", {8'd0, disp_data}, 32'h000705);

        // Illegal address, then clear
        send_frame(8'h09, 8'h01);
        end_frame("bad_addr", 1'b0, 1'b1);
        chk("bad_addr_disp", {8'd0, disp_data}, 32'h000705);
        send_frame(8'h08, 8'h00);
        end_frame("clr", 1'b1, 1'b0);
        chk("clr_disp", {8'd0, disp_data}, 32'h0);
        chk("clr_point", {26'd0, disp_point}, 32'h0);
        chk("clr_seg_en", {31'd0, seg_en}, 32'd0);

        // Byte during EXEC is dropped
        send_frame(8'h07, 8'h01);
        send_byte(8'hA5);
        chk("drop_ok", {31'd0, frame_ok}, 32'd1);
        chk("drop_seg_en", {31'd0, seg_en}, 32'd1);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        idle(1);
        send_byte(8'h00);
        idle(2);
        send_byte(8'h05);
        idle(3);
        chk("drop_busy2", {31'd0, busy}, 32'd0);
        chk("drop_disp", {8'd0, disp_data}, 32'h0);
        chk("drop_ok2", {31'd0, frame_ok}, 32'd0);

        // Inter-byte timeout after ADDR
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h03);
        chk("to_state", {29'd0, state_dbg}, 32'd2);
        idle(21699);
        chk("to_err_pre", {31'd0, frame_err}, 32'd0);
        chk("to_busy_pre", {31'd0, busy}, 32'd1);
        idle(1);
        exp_err_cnt = exp_err_cnt + 8'd1;
        chk("to_err", {31'd0, frame_err}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_errcnt", {24'd0, err_cnt}, {24'd0, exp_err_cnt});
        idle(1);
        chk("to_err_post", {31'd0, frame_err}, 32'd0);

        // Byte arriving on the terminal count wins
        send_byte(8'hA5);
        idle(21699);
        send_byte(8'h03);
        chk("tc_err", {31'd0, frame_err}, 32'd0);
        chk("tc_busy", {31'd0, busy}, 32'd1);
        idle(2);
        send_byte(8'h09);
`ifdef UART_FRAME_CKSUM_EN
        idle(2);
        send_byte(8'h0A);
`endif
        end_frame("tc", 1'b1, 1'b0);
        chk("tc_disp", {8'd0, disp_data}, 32'h009000);

        // Upper nibble ignored; A5 as DATA payload
        send_frame(8'h05, 8'hF8);
        end_frame("d5", 1'b1, 1'b0);
        chk("d5_disp", {8'd0, disp_data}, 32'h809000);
        send_frame(8'h04, 8'hA5);
        end_frame("d4", 1'b1, 1'b0);
        chk("d4_disp", {8'd0, disp_data}, 32'h859000);

`ifdef UART_FRAME_CKSUM_EN
        // Checksum good / bad
        send_frame(8'h01, 8'h04);
        end_frame("ck_good", 1'b1, 1'b0);
        chk("ck_good_disp", {8'd0, disp_data}, 32'h859040);
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h01);
        idle(2);
        send_byte(8'h03);
        idle(2);
        send_byte(8'h06);
        end_frame("ck_bad", 1'b0, 1'b1);
        chk("ck_bad_disp", {8'd0, disp_data}, 32'h859040);
`endif

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send_frame(8'h09, 8'h01);
            end_frame("sat", 1'b0, 1'b1);
        end
        chk("sat_final", {24'd0, err_cnt}, 32'hFF);

        // Reset mid-frame
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h02);
        sys_rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_disp", {8'd0, disp_data}, 32'h0);
        chk("mrst_seg_en", {31'd0, seg_en}, 32'd1);
        chk("mrst_errcnt", {24'd0, err_cnt}, 32'd0);
        chk("mrst_state", {29'd0, state_dbg}, 32'd0);
        idle(2);
        sys_rst_n = 1'b1;
        idle(2);
        send_byte(8'h07);
        idle(3);
        chk("mrst_after_busy", {31'd0, busy}, 32'd0);
        chk("mrst_after_disp", {8'd0, disp_data}, 32'h0);
        chk("mrst_after_ok", {31'd0, frame_ok}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
